// File: rtl/popcount_pkg.sv
// Shared types and constants for the sequential popcount controller.
//   state_t : controller FSM states
//   NIB_W   : width of the slice fed to the shared popcount unit
//   PC_W    : width of a single nibble's popcount (0..4)
package popcount_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int NIB_W = 4;
  localparam int PC_W  = 3;

endpackage

// File: rtl/popcount_nibble.sv
// Combinational 4-bit population count, implemented as a 16-entry table.
// Ports:
//   nib : 4-bit input slice
//   cnt : number of set bits in nib (0..4)
module popcount_nibble
  import popcount_pkg::*;
(
  input  logic [NIB_W-1:0] nib,
  output logic [PC_W-1:0]  cnt
);

  always_comb begin
    cnt = '0;
    case (nib)
      4'h0:                               cnt = 3'd0;
      4'h1, 4'h2, 4'h4, 4'h8:             cnt = 3'd1;
      4'h3, 4'h5, 4'h6, 4'h9, 4'hA, 4'hC: cnt = 3'd2;
      4'h7, 4'hB, 4'hD, 4'hE:             cnt = 3'd3;
      4'hF:                               cnt = 3'd4;
      default:                            cnt = 3'd0;
    endcase
  end

endmodule

// File: rtl/popcount_seq_ctrl.sv
// Sequential Hamming-weight unit: accepts a WORD_W-bit word on a valid/ready
// input, walks it one nibble per cycle (LSB nibble first) through a single
// shared popcount_nibble, and presents the total on a valid/ready output.
// Ports:
//   clk, rst             : clock, synchronous active-high reset
//   in_valid/in_ready    : input handshake; in_ready only in IDLE
//   in_data              : word to count, captured on accept
//   out_valid/out_ready  : output handshake; out_valid only in DONE
//   out_count            : set-bit count of the accepted word (held after use)
//   busy                 : high in RUN or DONE
module popcount_seq_ctrl
  import popcount_pkg::*;
#(
  parameter  int WORD_W = 32,
  localparam int NIB_N  = WORD_W / NIB_W,
  localparam int CNT_W  = $clog2(WORD_W + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [WORD_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CNT_W-1:0]  out_count,
  output logic              busy
);

  // idx needs at least one bit even for a single-nibble word
  localparam int IDX_W = (NIB_N > 1) ? $clog2(NIB_N) : 1;

  state_t             state, state_nxt;
  logic [WORD_W-1:0]  sh;
  logic [CNT_W-1:0]   acc;
  logic [IDX_W-1:0]   idx;
  logic [PC_W-1:0]    pc;
  logic [CNT_W-1:0]   sum;
  logic               last;

  popcount_nibble u_pc (
    .nib (sh[NIB_W-1:0]),
    .cnt (pc)
  );

  // acc never exceeds WORD_W, so CNT_W bits hold the sum without overflow
  assign sum  = acc + CNT_W'(pc);
  assign last = (idx == IDX_W'(NIB_N - 1));

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Outputs decode from registered state only; no input-to-output paths.
  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_nxt = RUN;
      end
      RUN: begin
        busy = 1'b1;
        if (last) state_nxt = DONE;
      end
      DONE: begin
        busy      = 1'b1;
        out_valid = 1'b1;
        if (out_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sh        <= '0;
      acc       <= '0;
      idx       <= '0;
      out_count <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            sh  <= in_data;
            acc <= '0;
            idx <= '0;
          end
        end
        RUN: begin
          acc <= sum;
          sh  <= sh >> NIB_W;
          idx <= idx + IDX_W'(1);
          if (last) out_count <= sum;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/popcount_seq_ctrl.md
# popcount_seq_ctrl

Sequencing controller for the 4-bit nibble population-count unit. It accepts a WORD_W-bit word over a valid/ready handshake, feeds it one nibble per cycle through a single shared nibble-popcount instance, and accumulates the partial counts. It presents the total set-bit count on a valid/ready output port. The block sits between a word producer and any consumer that needs Hamming weights, so one small combinational unit serves arbitrarily wide words.

## Interface
Parameters:
- WORD_W, default 32: input word width; must be a multiple of 4 and at least 4.
- NIB_N, derived as WORD_W/4: number of nibbles, which equals the number of RUN cycles.
- CNT_W, derived as $clog2(WORD_W+1): result width; 6 when WORD_W=32.

Ports (clock and reset first):
- clk, input, 1: single clock; all state changes on the rising edge.
- rst, input, 1: reset, synchronous and active-high.
- in_valid, input, 1: producer has a word.
- in_ready, output, 1: block can accept; equals (state==IDLE).
- in_data, input, WORD_W: word to count; sampled only on accept.
- out_valid, output, 1: out_count holds a finished result.
- out_ready, input, 1: consumer takes the result.
- out_count, output, CNT_W: number of 1 bits in the accepted word.
- busy, output, 1: high in RUN or DONE.

## Operation
- FSM states are IDLE, RUN and DONE.
- IDLE:
  - in_ready=1.
  - On the accept condition in_valid && in_ready, capture in_data into shift register sh, clear accumulator acc, set nibble counter idx=0, and go to RUN.
- RUN, each cycle:
  - acc <= acc + pc(sh[3:0]), where pc() is the nibble popcount (0..4, 3 bits) zero-extended to CNT_W.
  - sh <= sh >> 4; idx <= idx+1.
  - When idx==NIB_N-1, the final add is performed, out_count <= acc + pc(sh[3:0]), and the FSM goes to DONE.
- DONE:
  - out_valid=1 and out_count is stable.
  - When out_ready is sampled high, go to IDLE.
- Nibble order is least-significant first. The order does not affect the result, but it is fixed for waveform checks.
- Width rule: acc is never wider than CNT_W and never overflows, since the maximum value is WORD_W.
- in_valid outside IDLE is ignored; the producer must hold its word until in_ready.
- out_count keeps its last result after the handshake. It is meaningful only while out_valid=1.
- Reset:
  - State becomes IDLE.
  - out_valid=0, busy=0, out_count=0, acc=0, idx=0, sh=0.
  - in_ready=1 from the first cycle after the reset edge.
- Reset mid-operation, in RUN or DONE: the word in flight is discarded with no partial result, and the block returns to the reset values above.
- While rst=1, handshakes on either port have no effect.

## Timing
- Accept edge T: first RUN cycle is T+1, last RUN cycle is T+NIB_N.
- out_valid rises in cycle T+NIB_N+1, so latency is NIB_N+1 cycles (9 for WORD_W=32).
- With out_ready=1 already asserted: DONE lasts one cycle, IDLE is reached at T+NIB_N+2, and the next accept can occur at that edge.
- Throughput is one word per NIB_N+2 cycles; there is no overlap between words.
- Backpressure: DONE is held for any number of cycles with out_count unchanged.
- No combinational path from in_valid or out_ready to any output. in_ready, out_valid and busy decode only from registered state.

## Structure
- Shared package popcount_pkg holds:
  - state enum {IDLE, RUN, DONE};
  - NIB_W=4;
  - the nibble-popcount result width, 3.
- One sub-module, popcount_nibble: 4-bit input, 3-bit output, purely combinational 16-entry count table.
  - It is instantiated once, on sh[3:0].
  - It is the only arithmetic besides the accumulator adder and the idx incrementer.

## Test plan
- Reset, then accept in_data=0x00000000 with out_ready=1: out_valid rises 9 cycles after the accept with out_count=0; in_ready returns high the following cycle.
- Accept 0xFFFFFFFF: out_count=32, which is full-width (6'b100000) with no overflow. Accept 0x80000001: out_count=2. Accept 0x0F0F00A5: out_count=12.
- Backpressure: accept 0x12345678, hold out_ready=0 for 5 cycles after out_valid. out_count must stay 13 and out_valid high throughout; the transfer completes on the first cycle out_ready=1.
- Accept 0x000000FF, then drive in_valid=1 with 0xFFFFFFFF during RUN: in_ready stays 0, the first result is 8, and the second word is accepted only once IDLE is reached and then yields 32.
- Accept 0xFFFFFFFF, assert rst for one cycle at RUN cycle 4:
  - out_valid must never rise for that word;
  - all outputs take reset values;
  - a subsequent accept of 0x00000003 yields 2.
- Back-to-back: 20 random words with out_ready held high. Each result must match a reference popcount, with out_valid pulses exactly 10 cycles apart.
